// File: rtl/dpram_wconv.sv
// Dual-port RAM with independent write/read widths, registered read pipeline and a
// post-reset sequential clear engine. Single clock domain.
module dpram_wconv #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WR_DW      = 8,
  parameter int unsigned RD_DW      = 32,
  parameter int unsigned WR_ADDRW   = 5,
  parameter int unsigned RD_ADDRW   = 3,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_FIRST   = 0
) (
  input  logic                wclk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [WR_ADDRW-1:0] w_addr_ram,
  input  logic [WR_DW-1:0]    din,
  input  logic                re,
  input  logic [RD_ADDRW-1:0] r_addr_ram,
  output logic [RD_DW-1:0]    dout,
  output logic                dout_vld,
  output logic                init_busy
);

  localparam int unsigned MAX_DW   = (WR_DW > RD_DW) ? WR_DW : RD_DW;
  localparam int unsigned ROWS     = DEPTH * WR_DW / MAX_DW;
  localparam int unsigned WR_RATIO = MAX_DW / WR_DW;
  localparam int unsigned RD_RATIO = MAX_DW / RD_DW;
  localparam int unsigned RD_DEPTH = DEPTH * WR_DW / RD_DW;
  localparam int unsigned ROW_AW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [ROW_AW-1:0]   clr_row_q, clr_row_d;
  logic                clr_we;

  logic [MAX_DW-1:0]   mem [ROWS];

  logic                wr_in_range, rd_in_range, wr_acc, rd_acc;
  logic [ROW_AW-1:0]   wr_row, rd_row;
  int unsigned         wr_shift, rd_shift;
  logic [MAX_DW-1:0]   wr_mask, wr_data, rd_row_data, rd_merged;
  logic [RD_DW-1:0]    rd_data;

  logic                vld1_q, vld2_q;
  logic [RD_DW-1:0]    dout1_q, dout2_q;

  assign init_busy   = (state_q == StClear);
  assign wr_in_range = 32'(w_addr_ram) < DEPTH;
  assign rd_in_range = 32'(r_addr_ram) < RD_DEPTH;
  assign wr_acc      = we & ~init_busy & wr_in_range;
  assign rd_acc      = re & ~init_busy;

  // Narrow side is little-endian inside the wide row: slice k sits at bit k*min_dw.
  always_comb begin
    wr_row   = ROW_AW'(32'(w_addr_ram) / WR_RATIO);
    wr_shift = (32'(w_addr_ram) % WR_RATIO) * WR_DW;
    wr_mask  = MAX_DW'({WR_DW{1'b1}}) << wr_shift;
    wr_data  = MAX_DW'(din) << wr_shift;
    rd_row   = ROW_AW'(32'(r_addr_ram) / RD_RATIO);
    rd_shift = (32'(r_addr_ram) % RD_RATIO) * RD_DW;
  end

  always_comb begin
    rd_row_data = rd_in_range ? mem[rd_row] : '0;
    rd_merged   = rd_row_data;
    // Write-first forwarding only replaces the bits the write actually touches.
    if ((WR_FIRST != 0) && wr_acc && (wr_row == rd_row)) begin
      rd_merged = (rd_row_data & ~wr_mask) | (wr_data & wr_mask);
    end
    rd_data = rd_in_range ? RD_DW'(rd_merged >> rd_shift) : '0;
  end

  always_ff @(posedge wclk) begin
    if (clr_we) begin
      mem[clr_row_q] <= '0;
    end else if (wr_acc) begin
      mem[wr_row] <= (mem[wr_row] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (clr_row_q == ROW_AW'(ROWS - 1)) begin
          state_d = StReady;
        end else begin
          clr_row_d = clr_row_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      dout1_q <= '0;
      vld2_q  <= 1'b0;
      dout2_q <= '0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) dout1_q <= rd_data;
      vld2_q <= vld1_q;
      if (vld1_q) dout2_q <= dout1_q;
    end
  end

  assign dout     = (RD_LATENCY == 2) ? dout2_q : dout1_q;
  assign dout_vld = (RD_LATENCY == 2) ? vld2_q : vld1_q;

endmodule
